// File: rtl/write_track_unit.sv
// Write tracking for the p3/p4/p5 forwarding path: per-stage destination/data/valid,
// load-use stall generation and register-file commit. Optional STALL_COUNT_EN adds stall_count.
module write_track_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              p2_valid,
    input  logic              p2_write_en,
    input  logic [ADDR_W-1:0] p2_write_addr,
    input  logic              p2_is_load,
    input  logic              p2_read_en_A,
    input  logic              p2_read_en_B,
    input  logic [ADDR_W-1:0] p2_read_addr_A,
    input  logic [ADDR_W-1:0] p2_read_addr_B,
    input  logic              flush,
    input  logic [DATA_W-1:0] alu_result_p3,
    input  logic [DATA_W-1:0] mem_data_p4,
    output logic [ADDR_W-1:0] write_addr_p3,
    output logic [ADDR_W-1:0] write_addr_p4,
    output logic [ADDR_W-1:0] write_addr_p5,
    output logic [DATA_W-1:0] data_p3,
    output logic [DATA_W-1:0] data_p4,
    output logic [DATA_W-1:0] data_p5,
    output logic              write_valid_p3,
    output logic              write_valid_p4,
    output logic              write_valid_p5,
    output logic              stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
`ifdef STALL_COUNT_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    typedef struct packed {
        logic              v;
        logic              we;
        logic              ld;
        logic [ADDR_W-1:0] addr;
    } ctl_t;

    ctl_t              p3_q;
    ctl_t              p4_q;
    logic [DATA_W-1:0] p4_data_q;

    // Load data is resolved by the time an instruction reaches p5, so p5 keeps no load flag.
    logic              p5_v_q;
    logic              p5_we_q;
    logic [ADDR_W-1:0] p5_addr_q;
    logic [DATA_W-1:0] p5_data_q;

    logic hit_a;
    logic hit_b;
    logic accept;

    always_comb begin
        hit_a  = p2_read_en_A && (p2_read_addr_A == p3_q.addr);
        hit_b  = p2_read_en_B && (p2_read_addr_B == p3_q.addr);
        stall  = p3_q.v && p3_q.we && p3_q.ld && p2_valid && !flush && (hit_a || hit_b);
        accept = p2_valid && !flush && !stall;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p3_q      <= '0;
            p4_q      <= '0;
            p4_data_q <= '0;
            p5_v_q    <= 1'b0;
            p5_we_q   <= 1'b0;
            p5_addr_q <= '0;
            p5_data_q <= '0;
        end else begin
            p5_v_q    <= p4_q.v;
            p5_we_q   <= p4_q.we;
            p5_addr_q <= p4_q.addr;
            p5_data_q <= data_p4;
            p4_q      <= p3_q;
            p4_data_q <= data_p3;
            p3_q      <= accept ? ctl_t'({1'b1, p2_write_en, p2_is_load, p2_write_addr}) : ctl_t'('0);
        end
    end

    // Bubbles carry all-zero fields, so invalid stages naturally present address 0 and data 0.
    assign data_p3        = p3_q.v ? alu_result_p3 : '0;
    assign data_p4        = p4_q.ld ? mem_data_p4 : p4_data_q;
    assign data_p5        = p5_data_q;
    assign write_addr_p3  = p3_q.addr;
    assign write_addr_p4  = p4_q.addr;
    assign write_addr_p5  = p5_addr_q;
    assign write_valid_p3 = p3_q.v && p3_q.we && !p3_q.ld;
    assign write_valid_p4 = p4_q.v && p4_q.we;
    assign write_valid_p5 = p5_v_q && p5_we_q;

    assign rf_we    = write_valid_p5;
    assign rf_waddr = write_addr_p5;
    assign rf_wdata = data_p5;

`ifdef STALL_COUNT_EN
    logic [15:0] stall_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stall_count_q <= '0;
        else if (stall && (stall_count_q != 16'hFFFF))
            stall_count_q <= stall_count_q + 16'd1;
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_write_track_unit.sv
// Directed and randomized bench for write_track_unit, checked against an instruction-level
// model of the p3/p4/p5 write pipeline.
module tb_write_track_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        p2_valid;
    logic        p2_write_en;
    logic [2:0]  p2_write_addr;
    logic        p2_is_load;
    logic        p2_read_en_A;
    logic        p2_read_en_B;
    logic [2:0]  p2_read_addr_A;
    logic [2:0]  p2_read_addr_B;
    logic        flush;
    logic [15:0] alu_result_p3;
    logic [15:0] mem_data_p4;
    logic [2:0]  write_addr_p3;
    logic [2:0]  write_addr_p4;
    logic [2:0]  write_addr_p5;
    logic [15:0] data_p3;
    logic [15:0] data_p4;
    logic [15:0] data_p5;
    logic        write_valid_p3;
    logic        write_valid_p4;
    logic        write_valid_p5;
    logic        stall;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
`ifdef STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    write_track_unit #(.DATA_W(16), .ADDR_W(3)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .p2_valid       (p2_valid),
        .p2_write_en    (p2_write_en),
        .p2_write_addr  (p2_write_addr),
        .p2_is_load     (p2_is_load),
        .p2_read_en_A   (p2_read_en_A),
        .p2_read_en_B   (p2_read_en_B),
        .p2_read_addr_A (p2_read_addr_A),
        .p2_read_addr_B (p2_read_addr_B),
        .flush          (flush),
        .alu_result_p3  (alu_result_p3),
        .mem_data_p4    (mem_data_p4),
        .write_addr_p3  (write_addr_p3),
        .write_addr_p4  (write_addr_p4),
        .write_addr_p5  (write_addr_p5),
        .data_p3        (data_p3),
        .data_p4        (data_p4),
        .data_p5        (data_p5),
        .write_valid_p3 (write_valid_p3),
        .write_valid_p4 (write_valid_p4),
        .write_valid_p5 (write_valid_p5),
        .stall          (stall),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata)
`ifdef STALL_COUNT_EN
        ,
        .stall_count    (stall_count)
`endif
    );

    always #5 clock = ~clock;

    // One in-flight instruction; data is its final write value once known.
    typedef struct packed {
        logic        v;
        logic        we;
        logic        ld;
        logic [2:0]  addr;
        logic [15:0] data;
    } instr_t;

    instr_t      in_p3;
    instr_t      in_p4;
    instr_t      in_p5;
    logic [15:0] model_stalls;
    int          checks_total  = 0;
    int          checks_passed = 0;
    int          checks_failed = 0;

    task automatic expect_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_stall();
        logic reads_load;
        reads_load = (p2_read_en_A && p2_read_addr_A == in_p3.addr) ||
                     (p2_read_en_B && p2_read_addr_B == in_p3.addr);
        return in_p3.v && in_p3.we && in_p3.ld && p2_valid && !flush && reads_load;
    endfunction

    function automatic logic [15:0] model_data_p4();
        return in_p4.ld ? mem_data_p4 : in_p4.data;
    endfunction

    task automatic checkOutput();
        logic [15:0] exp_d3;
        logic        exp_wv5;
        exp_d3  = in_p3.v ? alu_result_p3 : 16'h0;
        exp_wv5 = in_p5.v && in_p5.we;
        expect_val("wv_p3",   16'(write_valid_p3), 16'(in_p3.v && in_p3.we && !in_p3.ld));
        expect_val("wv_p4",   16'(write_valid_p4), 16'(in_p4.v && in_p4.we));
        expect_val("wv_p5",   16'(write_valid_p5), 16'(exp_wv5));
        expect_val("addr_p3", 16'(write_addr_p3), 16'(in_p3.addr));
        expect_val("addr_p4", 16'(write_addr_p4), 16'(in_p4.addr));
        expect_val("addr_p5", 16'(write_addr_p5), 16'(in_p5.addr));
        expect_val("data_p3", data_p3, exp_d3);
        expect_val("data_p4", data_p4, model_data_p4());
        expect_val("data_p5", data_p5, in_p5.data);
        expect_val("stall",   16'(stall), 16'(model_stall()));
        expect_val("rf_we",   16'(rf_we), 16'(exp_wv5));
        expect_val("rf_waddr", 16'(rf_waddr), 16'(in_p5.addr));
        expect_val("rf_wdata", rf_wdata, in_p5.data);
`ifdef STALL_COUNT_EN
        expect_val("stall_count", stall_count, model_stalls);
`endif
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic ld, input logic [2:0] wa,
                                 input logic ra_en, input logic [2:0] ra,
                                 input logic rb_en, input logic [2:0] rb,
                                 input logic fl, input logic [15:0] alu, input logic [15:0] mem);
        p2_valid       = v;
        p2_write_en    = we;
        p2_is_load     = ld;
        p2_write_addr  = wa;
        p2_read_en_A   = ra_en;
        p2_read_addr_A = ra;
        p2_read_en_B   = rb_en;
        p2_read_addr_B = rb;
        flush          = fl;
        alu_result_p3  = alu;
        mem_data_p4    = mem;
        #1;
        checkOutput();
    endtask

    task automatic idle(input logic [15:0] alu, input logic [15:0] mem);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, alu, mem);
    endtask

    // Advance one clock: instructions move down one stage, p2 enters unless stalled or flushed.
    task automatic tick();
        instr_t next3;
        instr_t next4;
        instr_t next5;
        logic   st;
        st         = model_stall();
        next5      = in_p4;
        next5.data = model_data_p4();
        next4      = in_p3;
        next4.data = in_p3.v ? alu_result_p3 : 16'h0;
        next3      = '0;
        if (p2_valid && !flush && !st) begin
            next3.v    = 1'b1;
            next3.we   = p2_write_en;
            next3.ld   = p2_is_load;
            next3.addr = p2_write_addr;
        end
        @(posedge clock);
        in_p3 = next3;
        in_p4 = next4;
        in_p5 = next5;
        if (st && model_stalls != 16'hFFFF) model_stalls = model_stalls + 16'd1;
        #1;
    endtask

    task automatic clear_model();
        in_p3        = '0;
        in_p4        = '0;
        in_p5        = '0;
        model_stalls = 16'h0;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_model();
        p2_valid = 0; p2_write_en = 0; p2_is_load = 0; p2_write_addr = 0;
        p2_read_en_A = 0; p2_read_en_B = 0; p2_read_addr_A = 0; p2_read_addr_B = 0;
        flush = 0; alu_result_p3 = 0; mem_data_p4 = 0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        $display("[TB] reset state");
        idle(16'hAAAA, 16'h5555);

        $display("[TB] ALU chain r3");
        applyStimulus(1, 1, 0, 3'd3, 0, 3'd0, 0, 3'd0, 0, 16'h0, 16'h0);
        tick();
        idle(16'h1234, 16'h0);
        expect_val("chain_wv_p3", 16'(write_valid_p3), 16'h1);
        expect_val("chain_addr_p3", 16'(write_addr_p3), 16'h3);
        expect_val("chain_data_p3", data_p3, 16'h1234);
        tick();
        idle(16'h0, 16'h0);
        expect_val("chain_wv_p4", 16'(write_valid_p4), 16'h1);
        expect_val("chain_data_p4", data_p4, 16'h1234);
        tick();
        idle(16'h0, 16'h0);
        expect_val("chain_rf_we", 16'(rf_we), 16'h1);
        expect_val("chain_rf_waddr", 16'(rf_waddr), 16'h3);
        expect_val("chain_rf_wdata", rf_wdata, 16'h1234);
        tick();

        $display("[TB] load-use r2");
        applyStimulus(1, 1, 1, 3'd2, 0, 3'd0, 0, 3'd0, 0, 16'h0, 16'h0);
        tick();
        applyStimulus(1, 1, 0, 3'd5, 1, 3'd2, 0, 3'd0, 0, 16'h0, 16'h0);
        expect_val("lu_stall", 16'(stall), 16'h1);
        expect_val("lu_wv_p3", 16'(write_valid_p3), 16'h0);
        tick();
        applyStimulus(1, 1, 0, 3'd5, 1, 3'd2, 0, 3'd0, 0, 16'h0, 16'hBEEF);
        expect_val("lu_stall_once", 16'(stall), 16'h0);
        expect_val("lu_data_p4", data_p4, 16'hBEEF);
        expect_val("lu_wv_p4", 16'(write_valid_p4), 16'h1);
        tick();
        idle(16'h7777, 16'h0);
        expect_val("lu_advance_wv", 16'(write_valid_p3), 16'h1);
        expect_val("lu_advance_addr", 16'(write_addr_p3), 16'h5);
        tick();

        $display("[TB] both operands on one load");
        applyStimulus(1, 1, 1, 3'd6, 0, 3'd0, 0, 3'd0, 0, 16'h0, 16'h0);
        tick();
        applyStimulus(1, 0, 0, 3'd0, 1, 3'd6, 1, 3'd6, 0, 16'h0, 16'h0);
        expect_val("ab_stall", 16'(stall), 16'h1);
        tick();
        applyStimulus(1, 0, 0, 3'd0, 1, 3'd6, 1, 3'd6, 0, 16'h0, 16'h0102);
        expect_val("ab_single", 16'(stall), 16'h0);
        tick();
        idle(16'h0, 16'h0);
        expect_val("nowrite_wv_p3", 16'(write_valid_p3), 16'h0);
        tick();

        $display("[TB] flush over hazard");
        applyStimulus(1, 1, 1, 3'd4, 0, 3'd0, 0, 3'd0, 0, 16'h0, 16'h0);
        tick();
        applyStimulus(1, 1, 0, 3'd6, 1, 3'd4, 0, 3'd0, 1, 16'h0, 16'h0);
        expect_val("fl_stall", 16'(stall), 16'h0);
        tick();
        idle(16'h0, 16'h4444);
        expect_val("fl_bubble", 16'(write_valid_p3), 16'h0);
        tick();
        idle(16'h0, 16'h0);
        tick();
        idle(16'h0, 16'h0);
        expect_val("fl_no_commit", 16'(rf_we), 16'h0);
        tick();

        $display("[TB] back-to-back r1");
        applyStimulus(1, 1, 0, 3'd1, 0, 3'd0, 0, 3'd0, 0, 16'h0, 16'h0);
        tick();
        applyStimulus(1, 1, 0, 3'd1, 0, 3'd0, 0, 3'd0, 0, 16'h1, 16'h0);
        tick();
        applyStimulus(1, 1, 0, 3'd1, 0, 3'd0, 0, 3'd0, 0, 16'h2, 16'h0);
        tick();
        applyStimulus(1, 1, 0, 3'd7, 0, 3'd0, 0, 3'd0, 0, 16'h3, 16'h0);
        expect_val("b2b_d3", data_p3, 16'h3);
        expect_val("b2b_d4", data_p4, 16'h2);
        expect_val("b2b_d5", data_p5, 16'h1);
        expect_val("b2b_a3", 16'(write_addr_p3), 16'h1);
        expect_val("b2b_a4", 16'(write_addr_p4), 16'h1);
        expect_val("b2b_a5", 16'(write_addr_p5), 16'h1);

        $display("[TB] reset mid-stream");
        reset_n = 1'b0;
        #1;
        clear_model();
        expect_val("rst_wv_p3", 16'(write_valid_p3), 16'h0);
        expect_val("rst_wv_p4", 16'(write_valid_p4), 16'h0);
        expect_val("rst_wv_p5", 16'(write_valid_p5), 16'h0);
        expect_val("rst_stall", 16'(stall), 16'h0);
        expect_val("rst_rf_we", 16'(rf_we), 16'h0);
        checkOutput();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(16'h0, 16'h0);

`ifdef STALL_COUNT_EN
        $display("[TB] stall counter");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1, 1, 3'(k), 0, 3'd0, 0, 3'd0, 0, 16'h0, 16'h0);
            tick();
            applyStimulus(1, 0, 0, 3'd0, 0, 3'd0, 1, 3'(k), 0, 16'h0, 16'h0);
            tick();
            idle(16'h0, 16'h0);
            tick();
        end
        idle(16'h0, 16'h0);
        expect_val("stall_count_4", stall_count, 16'h4);
`endif

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                          1'($urandom_range(0, 7) == 0), 16'($urandom), 16'($urandom));
            tick();
        end
        idle(16'h0, 16'h0);

        if (checks_failed != 0)
            $display("[TB] %0d comparisons did not hold", checks_failed);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
